// File: rtl/miriscv_lsu_pkg.sv
// Shared LSU encodings and the response-buffer entry payload.
package miriscv_lsu_pkg;

  localparam int unsigned MEM_ACCESS_W     = 3;
  localparam int unsigned LSU_DATA_MAX_W   = 64;
  localparam int unsigned LSU_OFFSET_MAX_W = 3;

  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_WORD   = 3'd0;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_HALF   = 3'd1;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_BYTE   = 3'd2;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UHALF  = 3'd3;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UBYTE  = 3'd4;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_DOUBLE = 3'd5;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UWORD  = 3'd6;

  // Data field is sized for the widest XLEN; narrower builds use the low bits.
  typedef struct packed {
    logic [MEM_ACCESS_W-1:0]     size;
    logic [LSU_OFFSET_MAX_W-1:0] offset;
    logic                        done;
    logic                        drop;
    logic                        misaligned;
    logic [LSU_DATA_MAX_W-1:0]   data;
  } lsu_resp_entry_t;

endpackage

// File: rtl/miriscv_lsu_align.sv
// Load data aligner: selects the addressed field, sign/zero-extends it and
// flags offsets the access size cannot reach inside one XLEN word.
module miriscv_lsu_align
  import miriscv_lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [MEM_ACCESS_W-1:0]    i_size,
  input  logic [$clog2(XLEN/8)-1:0]  i_offset,
  input  logic [XLEN-1:0]            i_rdata,
  output logic [XLEN-1:0]            o_data_c,
  output logic                       o_misaligned_c
);

  localparam int unsigned NBYTES = XLEN / 8;

  logic [XLEN-1:0] w_shift;
  logic [63:0]     w_field;
  logic [31:0]     w_off;
  logic [63:0]     w_ext;
  logic            w_ok;

  assign w_shift = i_rdata >> {i_offset, 3'b000};
  assign w_field = 64'(w_shift);
  assign w_off   = 32'(i_offset);

  always_comb begin
    w_ok  = 1'b1;
    w_ext = '0;
    case (i_size)
      MEM_ACCESS_BYTE:   w_ext = {{56{w_field[7]}}, w_field[7:0]};
      MEM_ACCESS_UBYTE:  w_ext = {56'd0, w_field[7:0]};
      MEM_ACCESS_HALF: begin
        w_ok  = (w_off <= NBYTES - 2);
        w_ext = {{48{w_field[15]}}, w_field[15:0]};
      end
      MEM_ACCESS_UHALF: begin
        w_ok  = (w_off <= NBYTES - 2);
        w_ext = {48'd0, w_field[15:0]};
      end
      MEM_ACCESS_WORD: begin
        w_ok  = (w_off <= NBYTES - 4);
        w_ext = {{32{w_field[31]}}, w_field[31:0]};
      end
      MEM_ACCESS_UWORD: begin
        w_ok  = (XLEN == 64) && (w_off <= NBYTES - 4);
        w_ext = {32'd0, w_field[31:0]};
      end
      MEM_ACCESS_DOUBLE: begin
        w_ok  = (XLEN == 64) && (w_off == 32'd0);
        w_ext = w_field;
      end
      default: w_ok = 1'b0;
    endcase
  end

  assign o_data_c       = w_ok ? XLEN'(w_ext) : '0;
  assign o_misaligned_c = ~w_ok;

endmodule

// File: rtl/miriscv_lsu_resp_buffer.sv
// In-order load-response tracker with kill/drop and aligned delivery.
// Optional MIRISCV_LSU_RESP_RAW_EN adds raw rdata/offset outputs for RVFI.
module miriscv_lsu_resp_buffer
  import miriscv_lsu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        arstn_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [MEM_ACCESS_W-1:0]     req_size_i,
  input  logic [$clog2(XLEN/8)-1:0]   req_offset_i,
  input  logic                        kill_i,
  input  logic                        data_rvalid_i,
  input  logic [XLEN-1:0]             data_rdata_i,
  output logic                        resp_valid_o,
  input  logic                        resp_ready_i,
  output logic [XLEN-1:0]             resp_data_o,
  output logic                        resp_misaligned_o,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic                        idle_o,
  output logic                        spurious_o
`ifdef MIRISCV_LSU_RESP_RAW_EN
  ,
  output logic [XLEN-1:0]             resp_raw_rdata_o,
  output logic [$clog2(XLEN/8)-1:0]   resp_offset_o
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned OFF_W = $clog2(XLEN / 8);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0] r_wr_ptr, r_rsp_ptr, r_rd_ptr;
  lsu_resp_entry_t  r_entry [DEPTH];
  logic             r_spurious;

  logic [IDX_W-1:0] w_wr_idx, w_rsp_idx, w_rd_idx;
  logic [PTR_W-1:0] w_count;
  lsu_resp_entry_t  w_head, w_new;
  logic             w_alloc, w_inflight, w_fill, w_head_done, w_retire;
  logic [XLEN-1:0]  w_align_data;
  logic             w_align_mis;
  logic             w_unused;

  assign w_wr_idx    = r_wr_ptr[IDX_W-1:0];
  assign w_rsp_idx   = r_rsp_ptr[IDX_W-1:0];
  assign w_rd_idx    = r_rd_ptr[IDX_W-1:0];
  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign w_head      = r_entry[w_rd_idx];
  assign w_alloc     = req_valid_i & req_ready_o;
  assign w_inflight  = (r_rsp_ptr != r_wr_ptr);
  assign w_fill      = data_rvalid_i & w_inflight;
  assign w_head_done = (r_rd_ptr != r_rsp_ptr) & w_head.done;
  assign w_retire    = w_head_done & (w_head.drop | resp_ready_i);

  always_comb begin
    w_new        = '0;
    w_new.size   = req_size_i;
    w_new.offset = LSU_OFFSET_MAX_W'(req_offset_i);
  end

  miriscv_lsu_align #(.XLEN(XLEN)) u_align (
    .i_size         (r_entry[w_rsp_idx].size),
    .i_offset       (r_entry[w_rsp_idx].offset[OFF_W-1:0]),
    .i_rdata        (data_rdata_i),
    .o_data_c       (w_align_data),
    .o_misaligned_c (w_align_mis)
  );

  // Kill marks every slot; a same-cycle allocation overwrites its own slot clean.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_wr_ptr   <= '0;
      r_rsp_ptr  <= '0;
      r_rd_ptr   <= '0;
      r_spurious <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
    end else begin
      if (kill_i) begin
        for (int i = 0; i < DEPTH; i++) r_entry[i].drop <= 1'b1;
      end
      if (w_fill) begin
        r_entry[w_rsp_idx].done       <= 1'b1;
        r_entry[w_rsp_idx].misaligned <= w_align_mis;
        r_entry[w_rsp_idx].data       <= LSU_DATA_MAX_W'(w_align_data);
        r_rsp_ptr                     <= r_rsp_ptr + PTR_W'(1);
      end
      if (data_rvalid_i && !w_inflight) r_spurious <= 1'b1;
      if (w_retire) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_alloc) begin
        r_entry[w_wr_idx] <= w_new;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
    end
  end

  always_comb begin
    w_unused = 1'b0;
    for (int i = 0; i < DEPTH; i++) w_unused = w_unused ^ (^r_entry[i]);
  end

  assign req_ready_o       = (w_count < PTR_W'(DEPTH));
  assign resp_valid_o      = w_head_done & ~w_head.drop;
  assign resp_data_o       = resp_valid_o ? XLEN'(w_head.data) : '0;
  assign resp_misaligned_o = resp_valid_o & w_head.misaligned;
  assign count_o           = w_count;
  assign idle_o            = (w_count == '0);
  assign spurious_o        = r_spurious;

`ifdef MIRISCV_LSU_RESP_RAW_EN
  logic [XLEN-1:0] r_raw [DEPTH];

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int i = 0; i < DEPTH; i++) r_raw[i] <= '0;
    end else if (w_fill) begin
      r_raw[w_rsp_idx] <= data_rdata_i;
    end
  end

  assign resp_raw_rdata_o = resp_valid_o ? r_raw[w_rd_idx] : '0;
  assign resp_offset_o    = resp_valid_o ? w_head.offset[OFF_W-1:0] : '0;
`endif

endmodule

// File: tb/tb_miriscv_lsu_resp_buffer.sv
// Randomized bench for miriscv_lsu_resp_buffer against a queue-level model (XLEN 32 and 64).
module tb_miriscv_lsu_resp_buffer;
  import miriscv_lsu_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic arstn;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, kill, rvalid, resp_valid, resp_ready, resp_mis, idle, spurious;
  logic [2:0]  req_size, count;
  logic [1:0]  req_off;
  logic [31:0] rdata, resp_data;

  logic        req_valid64, req_ready64, rvalid64, resp_valid64, resp_ready64, resp_mis64, idle64, spurious64;
  logic [2:0]  req_size64, count64, req_off64;
  logic [63:0] rdata64, resp_data64;

`ifdef MIRISCV_LSU_RESP_RAW_EN
  logic [31:0] raw32;
  logic [1:0]  roff32;
  logic [63:0] raw64;
  logic [2:0]  roff64;
`endif

  miriscv_lsu_resp_buffer #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .arstn_i(arstn), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_size_i(req_size), .req_offset_i(req_off), .kill_i(kill), .data_rvalid_i(rvalid),
    .data_rdata_i(rdata), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_data_o(resp_data), .resp_misaligned_o(resp_mis), .count_o(count), .idle_o(idle),
    .spurious_o(spurious)
`ifdef MIRISCV_LSU_RESP_RAW_EN
    , .resp_raw_rdata_o(raw32), .resp_offset_o(roff32)
`endif
  );

  miriscv_lsu_resp_buffer #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
    .clk_i(clk), .arstn_i(arstn), .req_valid_i(req_valid64), .req_ready_o(req_ready64),
    .req_size_i(req_size64), .req_offset_i(req_off64), .kill_i(1'b0), .data_rvalid_i(rvalid64),
    .data_rdata_i(rdata64), .resp_valid_o(resp_valid64), .resp_ready_i(resp_ready64),
    .resp_data_o(resp_data64), .resp_misaligned_o(resp_mis64), .count_o(count64), .idle_o(idle64),
    .spurious_o(spurious64)
`ifdef MIRISCV_LSU_RESP_RAW_EN
    , .resp_raw_rdata_o(raw64), .resp_offset_o(roff64)
`endif
  );

  typedef struct {
    logic [2:0]  size;
    int          off;
    bit          done;
    bit          drop;
    bit          mis;
    logic [63:0] data;
  } ment_t;

  ment_t q[$];
  bit    m_spur;
  int    n_pass = 0;
  int    n_tot  = 0;

  // Field extraction by byte count: legal iff the whole field fits in the word.
  function automatic logic [64:0] ref_align(int xlen, logic [2:0] size, int off, logic [63:0] rd);
    int nb; bit sgn; bit ok; logic [63:0] v, m;
    ok = 1; nb = 1; sgn = 0;
    case (size)
      MEM_ACCESS_BYTE:   begin nb = 1; sgn = 1; end
      MEM_ACCESS_UBYTE:  begin nb = 1; sgn = 0; end
      MEM_ACCESS_HALF:   begin nb = 2; sgn = 1; end
      MEM_ACCESS_UHALF:  begin nb = 2; sgn = 0; end
      MEM_ACCESS_WORD:   begin nb = 4; sgn = 1; end
      MEM_ACCESS_UWORD:  begin nb = 4; sgn = 0; ok = (xlen == 64); end
      MEM_ACCESS_DOUBLE: begin nb = 8; sgn = 1; ok = (xlen == 64); end
      default:           ok = 0;
    endcase
    if (off + nb > xlen / 8) ok = 0;
    if (!ok) return {1'b1, 64'd0};
    v = rd >> (8 * off);
    m = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    v = v & m;
    if (sgn && v[8 * nb - 1]) v = v | ~m;
    if (xlen == 32) v[63:32] = 32'd0;
    return {1'b0, v};
  endfunction

  function automatic int n_done();
    int n = 0;
    while (n < q.size() && q[n].done) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic check_model();
    int  nd = n_done();
    bit  v  = (nd > 0) && !q[0].drop;
    chk("count", 64'(count), 64'(q.size()));
    chk("req_ready", 64'(req_ready), 64'(q.size() < DEPTH));
    chk("idle", 64'(idle), 64'(q.size() == 0));
    chk("resp_valid", 64'(resp_valid), 64'(v));
    chk("spurious", 64'(spurious), 64'(m_spur));
    if (v) begin
      chk("resp_data", 64'(resp_data), q[0].data);
      chk("resp_mis", 64'(resp_mis), 64'(q[0].mis));
    end
  endtask

  // One cycle on the XLEN=32 instance: drive, advance model, check at the next negedge.
  task automatic step(input bit push, input logic [2:0] sz, input int off, input bit k,
                      input bit rv, input logic [31:0] rd, input bit rdy);
    int nd = n_done();
    bit alloc = push && (q.size() < DEPTH);
    bit ret   = (nd > 0) && (q[0].drop || rdy);
    logic [64:0] r;
    ment_t e;
    req_valid = push; req_size = sz; req_off = 2'(off); kill = k;
    rvalid = rv; rdata = rd; resp_ready = rdy;
    if (rv) begin
      if (nd < q.size()) begin
        r = ref_align(32, q[nd].size, q[nd].off, {32'd0, rd});
        q[nd].done = 1; q[nd].mis = r[64]; q[nd].data = r[63:0];
      end else m_spur = 1;
    end
    if (k) foreach (q[i]) q[i].drop = 1;
    if (ret) void'(q.pop_front());
    if (alloc) begin
      e.size = sz; e.off = off; e.done = 0; e.drop = 0; e.mis = 0; e.data = '0;
      q.push_back(e);
    end
    @(negedge clk);
    req_valid = 0; kill = 0; rvalid = 0;
    check_model();
  endtask

  task automatic step64(input bit push, input logic [2:0] sz, input int off,
                        input bit rv, input logic [63:0] rd, input bit rdy);
    req_valid64 = push; req_size64 = sz; req_off64 = 3'(off);
    rvalid64 = rv; rdata64 = rd; resp_ready64 = rdy;
    @(negedge clk);
    req_valid64 = 0; rvalid64 = 0; resp_ready64 = 0;
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    req_valid = 0; req_size = '0; req_off = '0; kill = 0; rvalid = 0; rdata = '0; resp_ready = 0;
    req_valid64 = 0; req_size64 = '0; req_off64 = '0; rvalid64 = 0; rdata64 = '0; resp_ready64 = 0;
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
    chk("rst_resp_mis", 64'(resp_mis), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_spurious", 64'(spurious), 64'd0);
    chk("rst64_count", 64'(count64), 64'd0);
    chk("rst64_resp_valid", 64'(resp_valid64), 64'd0);
    q.delete();
    m_spur = 0;
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
  endtask

  logic [2:0]  t64_size [8];
  int          t64_off  [8];
  logic [63:0] t64_data [8];
  logic [64:0] r64;

  initial begin
    do_reset();
    check_model();

    // Signed byte at offset 3.
    step(1, MEM_ACCESS_BYTE, 3, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 32'h80FF_0000, 1);
    chk("t1_valid", 64'(resp_valid), 64'd1);
    chk("t1_data", 64'(resp_data), 64'hFFFF_FF80);
    step(0, 0, 0, 0, 0, 0, 1);

    // Fill to DEPTH, then pop frees a slot.
    for (int i = 0; i < 4; i++) step(1, MEM_ACCESS_WORD, 0, 0, 0, 0, 0);
    chk("t2_ready_full", 64'(req_ready), 64'd0);
    chk("t2_count_full", 64'(count), 64'd4);
    step(0, 0, 0, 0, 1, $urandom, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("t2_ready_after_pop", 64'(req_ready), 64'd1);
    chk("t2_count_after_pop", 64'(count), 64'd3);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, $urandom, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("t2_idle", 64'(idle), 64'd1);

    // Kill with two in flight: responses absorbed silently.
    step(1, MEM_ACCESS_WORD, 0, 0, 0, 0, 1);
    step(1, MEM_ACCESS_HALF, 2, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, (i < 2), 32'hCAFE_F00D, 1);
      chk("t3_no_valid", 64'(resp_valid), 64'd0);
    end
    chk("t3_idle", 64'(idle), 64'd1);

    // Kill with a same-cycle push: only the new entry is delivered.
    step(1, MEM_ACCESS_WORD, 0, 0, 0, 0, 0);
    step(1, MEM_ACCESS_HALF, 2, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hAAAA_AAAA, 0);
    step(0, 0, 0, 0, 1, 32'h1234_5678, 0);
    chk("t4_valid", 64'(resp_valid), 64'd1);
    chk("t4_data", 64'(resp_data), 64'h0000_1234);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("t4_idle", 64'(idle), 64'd1);

    // Misaligned word, then spurious rvalid.
    step(1, MEM_ACCESS_WORD, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0);
    chk("t5_valid", 64'(resp_valid), 64'd1);
    chk("t5_mis", 64'(resp_mis), 64'd1);
    chk("t5_data", 64'(resp_data), 64'd0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 32'h5555_5555, 1);
    chk("t5_spurious", 64'(spurious), 64'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1);
    chk("t5_spurious_sticky", 64'(spurious), 64'd1);

    // Random traffic after a fresh reset.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit inflight = (q.size() > n_done());
      step(($urandom % 2 == 1) && (q.size() < DEPTH), 3'($urandom % 8), int'($urandom % 4),
           ($urandom % 20) == 0, inflight && ($urandom % 2 == 1), $urandom,
           ($urandom % 4) != 0);
    end

    // Reset in the middle of traffic.
    step(1, MEM_ACCESS_BYTE, 1, 0, 0, 0, 0);
    step(1, MEM_ACCESS_HALF, 0, 0, 1, $urandom, 0);
    step64(1, MEM_ACCESS_WORD, 0, 0, 0, 0);
    do_reset();
    check_model();

    // XLEN=64 instance: table of size/offset/data cases.
    t64_size[0] = MEM_ACCESS_UWORD;  t64_off[0] = 4; t64_data[0] = 64'h8000_0001_DEAD_BEEF;
    t64_size[1] = MEM_ACCESS_DOUBLE; t64_off[1] = 0; t64_data[1] = 64'h0123_4567_89AB_CDEF;
    t64_size[2] = MEM_ACCESS_DOUBLE; t64_off[2] = 1; t64_data[2] = 64'h0123_4567_89AB_CDEF;
    t64_size[3] = MEM_ACCESS_WORD;   t64_off[3] = 4; t64_data[3] = 64'h8765_4321_0000_0000;
    t64_size[4] = MEM_ACCESS_WORD;   t64_off[4] = 5; t64_data[4] = 64'h8765_4321_0000_0000;
    t64_size[5] = MEM_ACCESS_HALF;   t64_off[5] = 6; t64_data[5] = 64'hF00D_0000_0000_0000;
    t64_size[6] = MEM_ACCESS_UHALF;  t64_off[6] = 7; t64_data[6] = 64'hF00D_0000_0000_0000;
    t64_size[7] = MEM_ACCESS_UBYTE;  t64_off[7] = 7; t64_data[7] = 64'hF00D_0000_0000_0000;
    for (int i = 0; i < 8; i++) begin
      step64(1, t64_size[i], t64_off[i], 0, 0, 0);
      step64(0, 0, 0, 1, t64_data[i], 0);
      r64 = ref_align(64, t64_size[i], t64_off[i], t64_data[i]);
      chk("x64_valid", 64'(resp_valid64), 64'd1);
      chk("x64_data", resp_data64, r64[63:0]);
      chk("x64_mis", 64'(resp_mis64), 64'(r64[64]));
      if (i == 0) chk("x64_uword_lit", resp_data64, 64'h0000_0000_8000_0001);
      if (i == 3) chk("x64_word_lit", resp_data64, 64'hFFFF_FFFF_8765_4321);
      step64(0, 0, 0, 0, 0, 1);
      chk("x64_idle", 64'(idle64), 64'd1);
    end
    chk("x64_spurious", 64'(spurious64), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
